// File: rtl/ram_rw_pkg.sv
// ram_rw_pkg
// Shared types and helpers for the RAM-port read/write engines.
//   mm2s_state_t : read-engine control states
//   beats()      : number of bus beats covering a byte count
//   last_keep()  : byte-enable mask for the final beat of a transfer
// Helpers work on a wide fixed width so any module parameterisation can
// call them and cast the result down to its own widths.
package ram_rw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mm2s_state_t;

    localparam int unsigned CALC_W     = 64;
    localparam int unsigned KEEP_MAX_W = 128;

    // ceil(nbytes / 2**bpb_lg)
    function automatic logic [CALC_W-1:0] beats(input logic [CALC_W-1:0] nbytes,
                                                input int unsigned       bpb_lg);
        logic [CALC_W-1:0] mask;
        logic [CALC_W-1:0] whole;
        mask  = (CALC_W'(1) << bpb_lg) - CALC_W'(1);
        whole = nbytes >> bpb_lg;
        return ((nbytes & mask) != '0) ? whole + CALC_W'(1) : whole;
    endfunction

    // Low (nbytes mod bpb) bits set; all ones when the count is beat-aligned.
    function automatic logic [KEEP_MAX_W-1:0] last_keep(input logic [CALC_W-1:0] nbytes,
                                                        input int unsigned       bpb_lg);
        logic [CALC_W-1:0] rem;
        rem = nbytes & ((CALC_W'(1) << bpb_lg) - CALC_W'(1));
        if (rem == '0)
            return '1;
        return (KEEP_MAX_W'(1) << rem) - KEEP_MAX_W'(1);
    endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// ram_resp_fifo
// Synchronous FIFO for RAM read responses / write data. Head word and
// flags are driven straight from registers, so nothing on the push side
// reaches the read side combinationally.
// Ports:
//   clk, rstn   clock, async active-low reset (empties the FIFO)
//   push, din   write side; a push while full is dropped
//   pop, dout   read side; dout is the head word, valid while !empty
//   full, empty occupancy flags
module ram_resp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/ram_mm2s_reader.sv
// ram_mm2s_reader
// Memory-to-stream read engine. Takes one descriptor (aligned base byte
// address, byte count), issues word reads on the RAM port, buffers the
// in-order responses and replays them as an AXI-Stream burst with
// tkeep/tlast.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   cmd_valid/ready/addr/bytes       descriptor handshake
//   rd_en/addr, rd_wait              read request (accepted on rd_en && !rd_wait)
//   rd_ack, rd_data                  in-order read responses
//   m_axis_tvalid/tready/tdata/tkeep/tlast  output stream
//   busy                             transfer in progress
//   done                             one-cycle pulse once the transfer drained
module ram_mm2s_reader
    import ram_rw_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_bytes,
    output logic                      rd_en,
    output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      rd_wait,
    input  logic                      rd_ack,
    input  logic [AXI_WIDTH-1:0]      rd_data,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [AXI_WIDTH-1:0]      m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      done
);

    localparam int BPB    = AXI_WIDTH / 8;
    localparam int BPB_LG = $clog2(BPB);
    localparam int CRD_W  = $clog2(FIFO_DEPTH + 1);

    mm2s_state_t               state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]      req_left, beat_left, n_beats;
    logic [BPB-1:0]            keep_last_r, n_keep;
    logic [CRD_W-1:0]          credits;

    logic cmd_acc, issue_ok, req_acc, strm_hs, xfer_active;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign n_beats = LEN_WIDTH'(beats(CALC_W'(cmd_bytes), BPB_LG));
    assign n_keep  = BPB'(last_keep(CALC_W'(cmd_bytes), BPB_LG));

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign xfer_active = (state == ISSUE) || (state == DRAIN);
    assign cmd_acc     = cmd_valid && cmd_ready;

    // A credit is a FIFO slot not yet claimed by an outstanding read or a
    // buffered beat, so a response always finds room.
    assign issue_ok = (state == ISSUE) && (credits != '0);
    assign rd_en    = issue_ok;
    assign rd_addr  = addr_r;
    assign req_acc  = issue_ok && !rd_wait;

    assign m_axis_tvalid = !fifo_empty;
    assign strm_hs       = m_axis_tvalid && m_axis_tready;
    assign fifo_pop      = strm_hs;
    // Responses outside a transfer are stale; the full guard only matters
    // if a responder ignores the credit scheme.
    assign fifo_push     = rd_ack && xfer_active && !fifo_full;

    assign m_axis_tlast = m_axis_tvalid && (beat_left == LEN_WIDTH'(1));
    assign m_axis_tkeep = (beat_left == LEN_WIDTH'(1)) ? keep_last_r : '1;

    ram_resp_fifo #(
        .WIDTH (AXI_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (rd_data),
        .pop   (fifo_pop),
        .dout  (m_axis_tdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid)
                    state_nxt = (n_beats == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (req_acc && req_left == LEN_WIDTH'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave on the final handshake itself so done lands the
                // very next cycle.
                if (beat_left == '0 || (strm_hs && beat_left == LEN_WIDTH'(1)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r      <= '0;
            req_left    <= '0;
            beat_left   <= '0;
            keep_last_r <= '1;
        end else if (cmd_acc) begin
            addr_r      <= cmd_addr;
            req_left    <= n_beats;
            beat_left   <= n_beats;
            keep_last_r <= n_keep;
        end else begin
            if (req_acc) begin
                addr_r   <= addr_r + AXI_ADDR_WIDTH'(BPB);
                req_left <= req_left - LEN_WIDTH'(1);
            end
            if (strm_hs)
                beat_left <= beat_left - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            credits <= CRD_W'(FIFO_DEPTH);
        else begin
            case ({req_acc, strm_hs})
                2'b10:   credits <= credits - CRD_W'(1);
                2'b01:   credits <= credits + CRD_W'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule
